// File: rtl/vga_timing_gen_if.sv
// Interface between the VGA timing master, the sprite renderers and the DAC pins.
// The master drives the scan coordinates and the registered pin outputs; pixel_in is the merged sprite colour.
interface vga_timing_gen_if;
    logic [7:0]  pixel_in;
    logic [10:0] hc;
    logic [10:0] vc;
    logic        pix_tick;
    logic        frame_start;
    logic        hsync;
    logic        vsync;
    logic        video_on;
    logic [2:0]  R;
    logic [2:0]  G;
    logic [1:0]  B;

    modport master (
        input  pixel_in,
        output hc, vc, pix_tick, frame_start, hsync, vsync, video_on, R, G, B
    );

    modport slave (
        output pixel_in,
        input  hc, vc, pix_tick, frame_start, hsync, vsync, video_on, R, G, B
    );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480 pixel-timing master: pixel-tick divider, hc/vc scan counters, registered sync/colour pins.
// Optional build macro VGA_BORDER_EN draws a one-pixel white frame around the active area.
module vga_timing_gen #(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned H_TOTAL = 800,
    parameter int unsigned H_SYNC  = 96,
    parameter int unsigned H_BP    = 144,
    parameter int unsigned H_FP    = 784,
    parameter int unsigned V_TOTAL = 521,
    parameter int unsigned V_SYNC  = 2,
    parameter int unsigned V_BP    = 31,
    parameter int unsigned V_FP    = 511
) (
    input logic             clk,
    input logic             rst_n,
    vga_timing_gen_if.master vga
);

    localparam int unsigned      DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [10:0]      H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0]      V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0]      H_SYNC_C = 11'(H_SYNC);
    localparam logic [10:0]      H_BP_C   = 11'(H_BP);
    localparam logic [10:0]      H_FP_C   = 11'(H_FP);
    localparam logic [10:0]      V_SYNC_C = 11'(V_SYNC);
    localparam logic [10:0]      V_BP_C   = 11'(V_BP);
    localparam logic [10:0]      V_FP_C   = 11'(V_FP);

    logic [DIV_W-1:0] div_q;
    logic             div_wrap;
    logic [10:0]      hc_q, vc_q;
    logic [10:0]      hc_nxt, vc_nxt;
    logic             pix_tick_q;
    logic             frame_start_q;
    logic             hsync_q, vsync_q, video_on_q;
    logic [7:0]       rgb_q;
    logic             active;
    logic [7:0]       rgb_nxt;

    // pix_tick is the registered divider wrap; counters and the pin stage both
    // advance on the edge that ends the pix_tick clk.
    always_comb begin
        div_wrap = (div_q == DIV_LAST);
        hc_nxt   = hc_q;
        vc_nxt   = vc_q;
        if (pix_tick_q) begin
            if (hc_q == H_LAST) begin
                hc_nxt = '0;
                vc_nxt = (vc_q == V_LAST) ? '0 : vc_q + 11'd1;
            end else begin
                hc_nxt = hc_q + 11'd1;
            end
        end
    end

    always_comb begin
        active  = (hc_q >= H_BP_C) && (hc_q < H_FP_C) &&
                  (vc_q >= V_BP_C) && (vc_q < V_FP_C);
        rgb_nxt = active ? vga.pixel_in : '0;
`ifdef VGA_BORDER_EN
        if (active && ((hc_q == H_BP_C) || (hc_q == H_FP_C - 11'd1) ||
                       (vc_q == V_BP_C) || (vc_q == V_FP_C - 11'd1)))
            rgb_nxt = '1;
`else
`endif
    end

    // frame_start looks at the post-edge counters so it lines up with the
    // pix_tick clk whose closing edge loads hc=vc=0, for any CLK_DIV.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q         <= '0;
            hc_q          <= '0;
            vc_q          <= '0;
            pix_tick_q    <= 1'b0;
            frame_start_q <= 1'b0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            video_on_q    <= 1'b0;
            rgb_q         <= '0;
        end else begin
            div_q         <= div_wrap ? '0 : div_q + DIV_W'(1);
            pix_tick_q    <= div_wrap;
            frame_start_q <= div_wrap && (hc_nxt == H_LAST) && (vc_nxt == V_LAST);
            hc_q          <= hc_nxt;
            vc_q          <= vc_nxt;
            if (pix_tick_q) begin
                rgb_q      <= rgb_nxt;
                video_on_q <= active;
                hsync_q    <= !(hc_q < H_SYNC_C);
                vsync_q    <= !(vc_q < V_SYNC_C);
            end
        end
    end

    assign vga.hc          = hc_q;
    assign vga.vc          = vc_q;
    assign vga.pix_tick    = pix_tick_q;
    assign vga.frame_start = frame_start_q;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.video_on    = video_on_q;
    assign vga.R           = rgb_q[7:5];
    assign vga.G           = rgb_q[4:2];
    assign vga.B           = rgb_q[1:0];

endmodule
